// File: rtl/hex_display_bank.sv
// Multi-digit active-low seven-segment controller: latched hex word with static,
// leading-zero blank, scroll and off modes, plus per-digit blinking.
module hex_display_bank #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLINK_DIV  = 25000000,
    parameter int unsigned SCROLL_DIV = 12500000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [1:0]              mode,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] segs,
    output logic                    scroll_wrap
);

    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam int unsigned SW = $clog2(SCROLL_DIV);
    localparam int unsigned OW = $clog2(NUM_DIGITS);

    localparam logic [1:0] MODE_LZB    = 2'b01;
    localparam logic [1:0] MODE_SCROLL = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_ph_q, blink_ph_d;
    logic                    blink_wrap_c;
    logic [SW-1:0]           scroll_cnt_q, scroll_cnt_d;
    logic [OW-1:0]           offset_q, offset_d;
    logic                    wrap_q, wrap_d;
    logic [7*NUM_DIGITS-1:0] segs_q, segs_d;

    logic [OW-1:0] rot;
    logic          seen_nz;
    logic [3:0]    nib;
    logic [6:0]    dig;
    int            src;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Shadow capture, free-running blink timebase and scroll stepping.
    always_comb begin
        shadow_d     = load ? value : shadow_q;
        blink_wrap_c = (blink_cnt_q == BW'(BLINK_DIV - 1));
        blink_cnt_d  = blink_wrap_c ? '0 : blink_cnt_q + BW'(1);
        blink_ph_d   = blink_ph_q ^ blink_wrap_c;

        scroll_cnt_d = '0;
        offset_d     = '0;
        wrap_d       = 1'b0;
        if (mode == MODE_SCROLL) begin
            if (scroll_cnt_q == SW'(SCROLL_DIV - 1)) begin
                // A load on the step edge restarts the scroll unrotated
                if (!load) begin
                    wrap_d   = (offset_q == OW'(NUM_DIGITS - 1));
                    offset_d = wrap_d ? '0 : offset_q + OW'(1);
                end
            end else begin
                scroll_cnt_d = scroll_cnt_q + SW'(1);
                offset_d     = offset_q;
            end
        end
    end

    // Per-digit segment selection; scans MSB first so leading zeros can be tracked.
    always_comb begin
        segs_d  = '1;
        seen_nz = 1'b0;
        nib     = '0;
        dig     = SEG_BLANK;
        src     = 0;
        rot     = (mode == MODE_SCROLL) ? offset_q : '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (i >= int'(rot)) src = i - int'(rot);
            else                src = i + int'(NUM_DIGITS) - int'(rot);
            nib     = shadow_q[4*src +: 4];
            seen_nz = seen_nz | (nib != 4'h0);
            dig     = hex7(nib);
            if (mode == MODE_LZB && !seen_nz && i != 0) dig = SEG_BLANK;
            if (mode == MODE_OFF)                       dig = SEG_BLANK;
            if (blink_ph_q && blink_mask[i])            dig = SEG_BLANK;
            segs_d[7*i +: 7] = dig;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            shadow_q     <= '0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            scroll_cnt_q <= '0;
            offset_q     <= '0;
            wrap_q       <= 1'b0;
            segs_q       <= '1;
        end else begin
            shadow_q     <= shadow_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            scroll_cnt_q <= scroll_cnt_d;
            offset_q     <= offset_d;
            wrap_q       <= wrap_d;
            segs_q       <= segs_d;
        end
    end

    assign segs        = segs_q;
    assign scroll_wrap = wrap_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank with 4 digits and short blink/scroll dividers.
module tb_hex_display_bank;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        load;
    logic [15:0] value;
    logic [1:0]  mode;
    logic [3:0]  blink_mask;
    logic [27:0] segs;
    logic        scroll_wrap;

    int tests = 0;
    int fails = 0;
    int wraps = 0;

    hex_display_bank #(
        .NUM_DIGITS (4),
        .BLINK_DIV  (4),
        .SCROLL_DIV (6)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .load        (load),
        .value       (value),
        .mode        (mode),
        .blink_mask  (blink_mask),
        .segs        (segs),
        .scroll_wrap (scroll_wrap)
    );

    always #5 Clk = ~Clk;

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check_segs(input string tag, input logic [27:0] exp);
        tests++;
        assert (segs === exp) else begin
            fails++;
            $error("FAIL %s: segs=%h expected %h", tag, segs, exp);
        end
    endtask

    task automatic check_wrap(input string tag, input logic exp);
        tests++;
        assert (scroll_wrap === exp) else begin
            fails++;
            $error("FAIL %s: scroll_wrap=%b expected %b", tag, scroll_wrap, exp);
        end
    endtask

    task automatic load_val(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
        step(1);
    endtask

    initial begin
        Reset = 1'b0; load = 1'b0; value = '0; mode = 2'b00; blink_mask = '0;
        step(2);
        check_segs("reset_blank", 28'hFFFFFFF);
        check_wrap("reset_wrap", 1'b0);

        Reset = 1'b1;
        load_val(16'h12AF);
        check_segs("static_12af", {7'h79, 7'h24, 7'h08, 7'h0E});

        mode = 2'b01;
        load_val(16'h0040);
        check_segs("lzb_0040", {7'h7F, 7'h7F, 7'h19, 7'h40});
        load_val(16'h0000);
        check_segs("lzb_zero", {7'h7F, 7'h7F, 7'h7F, 7'h40});

        mode = 2'b00;
        step(1);
        check_segs("static_zero", {7'h40, 7'h40, 7'h40, 7'h40});
        mode = 2'b11;
        step(1);
        check_segs("mode_off", 28'hFFFFFFF);
        check_wrap("off_wrap", 1'b0);

        mode = 2'b00;
        load_val(16'h8888);
        check_segs("static_8888", {7'h00, 7'h00, 7'h00, 7'h00});
        Reset = 1'b0;
        #1;
        check_segs("async_reset_static", 28'hFFFFFFF);

        // Blink from a clean reset so the phase timing is known
        step(1);
        Reset = 1'b1; blink_mask = 4'b0001; value = 16'h8888; load = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            logic [6:0] d0;
            step(1);
            if (c == 1) load = 1'b0;
            if (c >= 2) begin
                d0 = (((c - 1) / 4) % 2 == 1) ? 7'h7F : 7'h00;
                check_segs($sformatf("blink_c%0d", c), {7'h00, 7'h00, 7'h00, d0});
            end
        end

        blink_mask = '0; mode = 2'b10; value = 16'h1234; load = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step(1);
            if (c == 1) load = 1'b0;
            if (scroll_wrap) wraps++;
            if (c == 2)  check_segs("scroll_off0", {7'h79, 7'h24, 7'h30, 7'h19});
            if (c == 7)  check_segs("scroll_off1", {7'h24, 7'h30, 7'h19, 7'h79});
            if (c == 13) check_segs("scroll_off2", {7'h30, 7'h19, 7'h79, 7'h24});
            if (c == 19) check_segs("scroll_off3", {7'h19, 7'h79, 7'h24, 7'h30});
            if (c == 24) check_wrap("scroll_wrap_pulse", 1'b1);
            if (c == 25) check_segs("scroll_back0", {7'h79, 7'h24, 7'h30, 7'h19});
        end
        tests++;
        assert (wraps == 1) else begin
            fails++;
            $error("FAIL wrap_count: wraps=%0d expected 1", wraps);
        end

        // Load lands exactly on the next step edge
        step(4);
        value = 16'hABCD; load = 1'b1;
        step(1);
        load = 1'b0;
        check_wrap("load_on_step_wrap", 1'b0);
        step(1);
        check_segs("load_on_step_unrot", {7'h08, 7'h03, 7'h46, 7'h21});

        step(12);
        check_segs("abcd_off2", {7'h46, 7'h21, 7'h08, 7'h03});
        Reset = 1'b0;
        #1;
        check_segs("async_reset_scroll", 28'hFFFFFFF);
        check_wrap("async_reset_wrap", 1'b0);

        step(1);
        Reset = 1'b1; mode = 2'b00; value = 16'h1234; load = 1'b1;
        step(1);
        load = 1'b0; mode = 2'b10;
        for (int c = 2; c <= 8; c++) begin
            step(1);
            if (c == 7) begin
                check_segs("post_reset_unrot", {7'h79, 7'h24, 7'h30, 7'h19});
                check_wrap("post_reset_no_wrap", 1'b0);
            end
            if (c == 8) check_segs("post_reset_off1", {7'h24, 7'h30, 7'h19, 7'h79});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
